// File: rtl/wb_sram_pkg.sv
// Shared types and constants for the Wishbone-to-byte-SRAM controller.
package wb_sram_pkg;
  localparam int DEF_ADDR_W = 17;
  localparam int DEF_WB_DW  = 32;
  localparam int NUM_LANES  = 4;
  localparam int LANE_W     = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_CAP  = 3'd2,
    WR      = 3'd3,
    ACK     = 3'd4
  } state_t;

  // Lowest enabled byte lane; 0 when nothing is enabled.
  function automatic logic [LANE_W-1:0] first_lane(input logic [NUM_LANES-1:0] sel);
    first_lane = '0;
    for (int i = NUM_LANES-1; i >= 0; i--)
      if (sel[i]) first_lane = LANE_W'(i);
  endfunction
endpackage

// File: rtl/wb_sram_lane_sel.sv
// Finds the next enabled byte lane strictly above the current one.
module wb_sram_lane_sel
  import wb_sram_pkg::*;
(
  input  logic [NUM_LANES-1:0] sel,
  input  logic [LANE_W-1:0]    cur,
  output logic [LANE_W-1:0]    nxt,
  output logic                 none
);
  always_comb begin
    nxt  = cur;
    none = 1'b1;
    // Descending scan so the lowest qualifying lane wins.
    for (int i = NUM_LANES-1; i >= 0; i--)
      if (i > int'(cur) && sel[i]) begin
        nxt  = LANE_W'(i);
        none = 1'b0;
      end
  end
endmodule

// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave driving an 8-bit async SRAM, one byte lane per access.
module wb_sram_ctrl
  import wb_sram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WB_DW  = DEF_WB_DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [WB_DW-1:0]  wb_dat_i,
  output logic [WB_DW-1:0]  wb_dat_o,
  input  logic [3:0]        wb_sel_i,
  output logic              wb_ack_o,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [7:0]        sram_data,
  output logic              sram_ce,
  output logic              sram_we,
  output logic              sram_oe
);
  state_t              state, nstate;
  logic [ADDR_W-3:0]   adr_word, acc_word;
  logic [WB_DW-1:0]    dat, acc_dat;
  logic [3:0]          sel;
  logic                we_q;
  logic [LANE_W-1:0]   lane, nlane, nxt_lane;
  logic                none_left, accept, drive;
  logic [7:0]          dout;
  logic                unused_adr;

  assign unused_adr = ^wb_adr_i[1:0];

  wb_sram_lane_sel u_lane_sel (
    .sel  (sel),
    .cur  (lane),
    .nxt  (nxt_lane),
    .none (none_left)
  );

  // On the acceptance edge the latches are not yet loaded, so bypass them.
  assign acc_word = accept ? wb_adr_i[ADDR_W-1:2] : adr_word;
  assign acc_dat  = accept ? wb_dat_i : dat;

  always_comb begin
    nstate = state;
    nlane  = lane;
    accept = 1'b0;
    case (state)
      IDLE:
        if (wb_cyc_i && wb_stb_i) begin
          accept = 1'b1;
          nlane  = first_lane(wb_sel_i);
          if (wb_sel_i == 4'h0) nstate = ACK;
          else if (wb_we_i)     nstate = WR;
          else                  nstate = RD_ADDR;
        end
      RD_ADDR: nstate = RD_CAP;
      RD_CAP, WR:
        if (none_left) nstate = ACK;
        else begin
          nstate = we_q ? WR : RD_ADDR;
          nlane  = nxt_lane;
        end
      ACK:     nstate = IDLE;
      default: nstate = IDLE;
    endcase
    if (state != IDLE && !wb_cyc_i) nstate = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lane      <= '0;
      adr_word  <= '0;
      dat       <= '0;
      sel       <= '0;
      we_q      <= 1'b0;
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
      sram_addr <= '0;
      sram_ce   <= 1'b1;
      sram_we   <= 1'b1;
      sram_oe   <= 1'b1;
      drive     <= 1'b0;
      dout      <= '0;
    end else begin
      state <= nstate;
      lane  <= nlane;
      if (accept) begin
        adr_word <= wb_adr_i[ADDR_W-1:2];
        dat      <= wb_dat_i;
        sel      <= wb_sel_i;
        we_q     <= wb_we_i;
        wb_dat_o <= '0;
      end
      if (state == RD_CAP) wb_dat_o[{lane, 3'b000} +: 8] <= sram_data;
      // Strobes are registered from the state being entered.
      wb_ack_o <= (nstate == ACK);
      sram_ce  <= !(nstate inside {RD_ADDR, RD_CAP, WR});
      sram_we  <= !(nstate == WR);
      sram_oe  <= !(nstate == RD_CAP);
      drive    <= (nstate == WR);
      if (nstate inside {RD_ADDR, RD_CAP, WR}) begin
        sram_addr <= {acc_word, nlane};
        dout      <= acc_dat[{nlane, 3'b000} +: 8];
      end
    end
  end

  assign sram_data = drive ? dout : 8'bz;
endmodule
